// File: rtl/el2_dec_trigger_csr_if.sv
// CSR access port of the debug-trigger block: one write channel and one
// combinational read channel, both 12-bit addressed.
interface el2_dec_trigger_csr_if;
    logic        csr_wr_valid;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;

    modport master (
        output csr_wr_valid,
        output csr_wr_addr,
        output csr_wr_data,
        output csr_rd_addr,
        input  csr_rd_data
    );

    modport slave (
        input  csr_wr_valid,
        input  csr_wr_addr,
        input  csr_wr_data,
        input  csr_rd_addr,
        output csr_rd_data
    );
endinterface

// File: rtl/el2_dec_trigger_csr.sv
// Debug trigger CSRs (tselect/tdata1/tdata2) for four mcontrol triggers, with
// chaining, commit qualification, hit tracking and registered halt/ebreak requests.
module el2_dec_trigger_csr (
    input  logic                  clk,
    input  logic                  rst,
    el2_dec_trigger_csr_if.slave  csr,
    input  logic                  dbg_mode,
    input  logic [3:0]            lsu_trigger_match_m,
    input  logic                  lsu_commit_m,
    // per trigger: {select, match, store, load, execute, m, tdata2[31:0]}
    output logic [3:0][37:0]      trigger_pkt_any,
    output logic [3:0]            trigger_fire_m,
    output logic                  trigger_halt_req,
    output logic                  trigger_ebreak_req
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
    localparam logic [31:0] TDATA1_FIXED = 32'h23E0_0000;
    localparam logic [3:0]  CHAIN_IMPL   = 4'b0101;

    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
        logic store;
        logic load;
    } mctl_t;

    function automatic mctl_t decode_tdata1(input logic [31:0] wdata,
                                            input logic        dbg,
                                            input logic        chain_en);
        mctl_t r;
        r.dmode   = wdata[27] & dbg;
        r.hit     = wdata[20];
        r.select  = wdata[19];
        r.action  = (wdata[15:12] == 4'd1);
        r.chain   = wdata[11] & chain_en;
        r.match   = (wdata[10:7] == 4'd1);
        r.m       = wdata[6];
        r.execute = wdata[2];
        r.store   = wdata[1];
        r.load    = wdata[0];
        return r;
    endfunction

    function automatic logic [31:0] encode_tdata1(input mctl_t c);
        logic [31:0] r;
        r     = TDATA1_FIXED;
        r[27] = c.dmode;
        r[20] = c.hit;
        r[19] = c.select;
        r[12] = c.action;
        r[11] = c.chain;
        r[7]  = c.match;
        r[6]  = c.m;
        r[2]  = c.execute;
        r[1]  = c.store;
        r[0]  = c.load;
        return r;
    endfunction

    // A chained pair fires both members or neither.
    function automatic logic [1:0] fire_pair(input logic [1:0] raw, input logic chain);
        logic [1:0] f;
        if (chain) begin
            f = {2{raw[0] & raw[1]}};
        end else begin
            f = raw;
        end
        return f;
    endfunction

    logic [1:0]        tselect_q, tselect_d;
    mctl_t [3:0]       mctl_q, mctl_d;
    logic [3:0][31:0]  tdata2_q, tdata2_d;
    logic              halt_q, halt_d;
    logic              ebreak_q, ebreak_d;

    logic [3:0]        raw_s;
    logic [3:0]        fire_s;
    logic [3:0]        action_s;
    logic              wr_tsel_s;
    logic              wr_td1_s;
    logic              wr_td2_s;
    logic              wr_unlocked_s;

    assign wr_tsel_s     = csr.csr_wr_valid & (csr.csr_wr_addr == ADDR_TSELECT);
    assign wr_td1_s      = csr.csr_wr_valid & (csr.csr_wr_addr == ADDR_TDATA1);
    assign wr_td2_s      = csr.csr_wr_valid & (csr.csr_wr_addr == ADDR_TDATA2);
    assign wr_unlocked_s = ~mctl_q[tselect_q].dmode | dbg_mode;

    // Commit-qualified raw matches, chaining, and request next-state.
    always_comb begin
        raw_s       = lsu_trigger_match_m & {4{lsu_commit_m & ~dbg_mode}};
        fire_s[1:0] = fire_pair(raw_s[1:0], mctl_q[0].chain);
        fire_s[3:2] = fire_pair(raw_s[3:2], mctl_q[2].chain);
        for (int i = 0; i < 4; i++) begin
            action_s[i] = mctl_q[i].action;
        end
        halt_d   = |(fire_s & action_s);
        ebreak_d = |(fire_s & ~action_s);
    end

    assign trigger_fire_m = fire_s & {4{~rst}};

    // CSR writes and hit capture; a tdata1 write overrides a same-cycle hit.
    always_comb begin
        mctl_d   = mctl_q;
        tdata2_d = tdata2_q;
        if (wr_tsel_s && (csr.csr_wr_data[31:2] == 30'd0)) begin
            tselect_d = csr.csr_wr_data[1:0];
        end else begin
            tselect_d = tselect_q;
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_td1_s && wr_unlocked_s && (tselect_q == 2'(i))) begin
                mctl_d[i] = decode_tdata1(csr.csr_wr_data, dbg_mode, CHAIN_IMPL[i]);
            end else if (fire_s[i]) begin
                mctl_d[i].hit = 1'b1;
            end else begin
                mctl_d[i] = mctl_q[i];
            end
            if (wr_td2_s && wr_unlocked_s && (tselect_q == 2'(i))) begin
                tdata2_d[i] = csr.csr_wr_data;
            end else begin
                tdata2_d[i] = tdata2_q[i];
            end
        end
    end

    // Read mux; unowned addresses return zero.
    always_comb begin
        case (csr.csr_rd_addr)
            ADDR_TSELECT: csr.csr_rd_data = {30'd0, tselect_q};
            ADDR_TDATA1:  csr.csr_rd_data = encode_tdata1(mctl_q[tselect_q]);
            ADDR_TDATA2:  csr.csr_rd_data = tdata2_q[tselect_q];
            default:      csr.csr_rd_data = 32'd0;
        endcase
    end

    // Trigger packet straight from stored state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            trigger_pkt_any[i] = {mctl_q[i].select, mctl_q[i].match, mctl_q[i].store,
                                  mctl_q[i].load, mctl_q[i].execute, mctl_q[i].m,
                                  tdata2_q[i]};
        end
    end

    // State and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tselect_q <= 2'd0;
            mctl_q    <= 40'd0;
            tdata2_q  <= 128'd0;
            halt_q    <= 1'b0;
            ebreak_q  <= 1'b0;
        end else begin
            tselect_q <= tselect_d;
            mctl_q    <= mctl_d;
            tdata2_q  <= tdata2_d;
            halt_q    <= halt_d;
            ebreak_q  <= ebreak_d;
        end
    end

    assign trigger_halt_req   = halt_q;
    assign trigger_ebreak_req = ebreak_q;

endmodule

// File: tb/tb_el2_dec_trigger_csr.sv
// Bench for el2_dec_trigger_csr: CSR vector table, directed chaining/dmode/
// conflict/reset sequences, then random traffic against a reference model.
module tb_el2_dec_trigger_csr;

    logic             clk = 1'b0;
    logic             rst;
    logic             dbg_mode;
    logic [3:0]       match;
    logic             commit;
    logic [3:0][37:0] pkt;
    logic [3:0]       fire;
    logic             halt;
    logic             ebreak;

    el2_dec_trigger_csr_if bus();

    el2_dec_trigger_csr dut (
        .clk                 (clk),
        .rst                 (rst),
        .csr                 (bus.slave),
        .dbg_mode            (dbg_mode),
        .lsu_trigger_match_m (match),
        .lsu_commit_m        (commit),
        .trigger_pkt_any     (pkt),
        .trigger_fire_m      (fire),
        .trigger_halt_req    (halt),
        .trigger_ebreak_req  (ebreak)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wv;
        logic [11:0] wa;
        logic [31:0] wd;
        logic [11:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Reference model: full architectural register words.
    logic [31:0] m_td1[4];
    logic [31:0] m_td2[4];
    int          m_tsel;
    bit          m_halt;
    bit          m_ebreak;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_wr_valid = 1'b1;
        bus.csr_wr_addr  = a;
        bus.csr_wr_data  = d;
        tick();
        bus.csr_wr_valid = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_rd_addr = a;
        @(negedge clk);
        check(name, bus.csr_rd_data, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_td1[i] = 32'h23E0_0000;
            m_td2[i] = 32'h0;
        end
        m_tsel   = 0;
        m_halt   = 1'b0;
        m_ebreak = 1'b0;
    endfunction

    function automatic logic [31:0] model_legal_td1(input logic [31:0] wd, input bit dbg, input int idx);
        logic [31:0] v;
        v = 32'h23E0_0000 | (wd & 32'h0018_0047);
        if (dbg && wd[27]) v[27] = 1'b1;
        if (wd[15:12] == 4'd1) v[12] = 1'b1;
        if (wd[10:7] == 4'd1) v[7] = 1'b1;
        if ((idx == 0 || idx == 2) && wd[11]) v[11] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] model_fire(input logic [3:0] mt, input bit cm, input bit dbg);
        logic [3:0] raw;
        logic [3:0] f;
        raw = (cm && !dbg) ? mt : 4'b0000;
        f   = raw;
        for (int p = 0; p < 4; p += 2) begin
            if (m_td1[p][11]) begin
                f[p]   = raw[p] & raw[p+1];
                f[p+1] = f[p];
            end
        end
        return f;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] r;
        case (a)
            12'h7A0: r = 32'(m_tsel);
            12'h7A1: r = m_td1[m_tsel];
            12'h7A2: r = m_td2[m_tsel];
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [37:0] model_pkt(input int i);
        return {m_td1[i][19], m_td1[i][7], m_td1[i][1], m_td1[i][0], m_td1[i][2], m_td1[i][6], m_td2[i]};
    endfunction

    task automatic model_step(input bit wv, input logic [11:0] wa, input logic [31:0] wd,
                              input logic [3:0] mt, input bit cm, input bit dbg);
        logic [3:0] f;
        bit         locked;
        f        = model_fire(mt, cm, dbg);
        m_halt   = 1'b0;
        m_ebreak = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f[i]) begin
                m_td1[i][20] = 1'b1;
                if (m_td1[i][12]) m_halt = 1'b1;
                else m_ebreak = 1'b1;
            end
        end
        locked = m_td1[m_tsel][27] && !dbg;
        if (wv) begin
            case (wa)
                12'h7A0: if (wd <= 32'd3) m_tsel = int'(wd[1:0]);
                12'h7A1: if (!locked) m_td1[m_tsel] = model_legal_td1(wd, dbg, m_tsel);
                12'h7A2: if (!locked) m_td2[m_tsel] = wd;
                default: ;
            endcase
        end
    endtask

    initial begin
        rst              = 1'b1;
        dbg_mode         = 1'b0;
        match            = 4'hF;
        commit           = 1'b1;
        bus.csr_wr_valid = 1'b0;
        bus.csr_wr_addr  = 12'h0;
        bus.csr_wr_data  = 32'h0;
        bus.csr_rd_addr  = 12'h7A1;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,         12'h7A1, 32'h23E0_0000};
        vecs[1]  = '{1'b0, 12'h000, 32'h0,         12'h7A2, 32'h0};
        vecs[2]  = '{1'b0, 12'h000, 32'h0,         12'h7A0, 32'h0};
        vecs[3]  = '{1'b1, 12'h7A0, 32'h1,         12'h7A1, 32'h23E0_0000};
        vecs[4]  = '{1'b1, 12'h7A0, 32'h3,         12'h7A0, 32'h3};
        vecs[5]  = '{1'b1, 12'h7A0, 32'h2,         12'h7A2, 32'h0};
        vecs[6]  = '{1'b1, 12'h7A1, 32'h0000_10C7, 12'h7A1, 32'h23E0_10C7};
        vecs[7]  = '{1'b1, 12'h7A2, 32'h8000_0FFF, 12'h7A2, 32'h8000_0FFF};
        vecs[8]  = '{1'b1, 12'h7A0, 32'h3,         12'h7A1, 32'h23E0_0000};
        vecs[9]  = '{1'b1, 12'h7A1, 32'hFFFF_FFFF, 12'h7A1, 32'h23F8_0047};
        vecs[10] = '{1'b1, 12'h7A0, 32'h5,         12'h7A0, 32'h3};
        vecs[11] = '{1'b1, 12'h7A1, 32'h0,         12'h7A1, 32'h23E0_0000};
        vecs[12] = '{1'b1, 12'h7A0, 32'h2,         12'h7A1, 32'h23E0_10C7};
        vecs[13] = '{1'b0, 12'h000, 32'h0,         12'h7A3, 32'h0};

        // Reset state, with matches driven to show fire is held off.
        tick();
        @(negedge clk);
        check("rst_fire", fire, 4'b0000);
        check("rst_pkt", pkt, 152'h0);
        check("rst_halt", halt, 1'b0);
        check("rst_ebreak", ebreak, 1'b0);
        check("rst_tdata1", bus.csr_rd_data, 32'h23E0_0000);
        match  = 4'h0;
        commit = 1'b0;
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.csr_wr_valid = vecs[i].wv;
            bus.csr_wr_addr  = vecs[i].wa;
            bus.csr_wr_data  = vecs[i].wd;
            bus.csr_rd_addr  = vecs[i].ra;
            tick();
            bus.csr_wr_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d", i), bus.csr_rd_data, vecs[i].exp);
        end
        check("pkt2", pkt[2], 38'h1F_8000_0FFF);
        check("pkt0", pkt[0], 38'h0);
        check("pkt1", pkt[1], 38'h0);
        check("pkt3", pkt[3], 38'h0);

        // Trigger 2 fires with action=1: one-cycle halt pulse, hit set.
        tick();
        match           = 4'b0100;
        commit          = 1'b1;
        bus.csr_rd_addr = 12'h7A1;
        @(negedge clk);
        check("t2_fire", fire, 4'b0100);
        tick();
        match  = 4'b0000;
        commit = 1'b0;
        @(negedge clk);
        check("t2_halt", halt, 1'b1);
        check("t2_ebreak", ebreak, 1'b0);
        check("t2_hit", bus.csr_rd_data, 32'h23F0_10C7);
        tick();
        @(negedge clk);
        check("t2_halt_pulse", halt, 1'b0);

        // Chain 0/1 with action=0 on both.
        tick();
        wr(12'h7A0, 32'h0);
        wr(12'h7A1, 32'h0000_0804);
        wr(12'h7A0, 32'h1);
        wr(12'h7A1, 32'h0000_0004);
        match  = 4'b0001;
        commit = 1'b1;
        @(negedge clk);
        check("chain_half_fire", fire, 4'b0000);
        tick();
        match  = 4'b0000;
        commit = 1'b0;
        @(negedge clk);
        check("chain_half_ebreak", ebreak, 1'b0);
        check("chain_half_hit1", bus.csr_rd_data, 32'h23E0_0004);
        tick();
        match  = 4'b0011;
        commit = 1'b1;
        @(negedge clk);
        check("chain_fire", fire, 4'b0011);
        tick();
        match  = 4'b0000;
        commit = 1'b0;
        @(negedge clk);
        check("chain_ebreak", ebreak, 1'b1);
        check("chain_halt", halt, 1'b0);
        check("chain_hit1", bus.csr_rd_data, 32'h23F0_0004);
        tick();
        wr(12'h7A0, 32'h0);
        rd_check("chain_hit0", 12'h7A1, 32'h23F0_0804);

        // dmode protection on trigger 1, and an out-of-range tselect write.
        tick();
        dbg_mode = 1'b1;
        wr(12'h7A0, 32'h1);
        wr(12'h7A1, 32'h0800_0004);
        dbg_mode = 1'b0;
        rd_check("dmode_set", 12'h7A1, 32'h2BE0_0004);
        tick();
        wr(12'h7A1, 32'h0);
        wr(12'h7A2, 32'h0000_1234);
        rd_check("dmode_td1", 12'h7A1, 32'h2BE0_0004);
        rd_check("dmode_td2", 12'h7A2, 32'h0);
        tick();
        wr(12'h7A0, 32'h5);
        rd_check("tsel_oob", 12'h7A0, 32'h1);

        // Same-cycle tdata1 write and fire, then reset during the request cycle.
        tick();
        wr(12'h7A0, 32'h2);
        bus.csr_rd_addr  = 12'h7A1;
        bus.csr_wr_valid = 1'b1;
        bus.csr_wr_addr  = 12'h7A1;
        bus.csr_wr_data  = 32'h0000_10C7;
        match            = 4'b0100;
        commit           = 1'b1;
        tick();
        bus.csr_wr_valid = 1'b0;
        match            = 4'b0000;
        commit           = 1'b0;
        check("conflict_hit", bus.csr_rd_data, 32'h23E0_10C7);
        check("conflict_halt", halt, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_halt", halt, 1'b0);
        match  = 4'b1111;
        commit = 1'b1;
        @(negedge clk);
        check("rst_mid_fire", fire, 4'b0000);
        check("rst_mid_pkt2", pkt[2], 38'h0);
        tick();
        match  = 4'b0000;
        commit = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_halt", halt, 1'b0);
        check("post_rst_tdata1", bus.csr_rd_data, 32'h23E0_0000);
        tick();
        @(negedge clk);
        check("post_rst_halt2", halt, 1'b0);
        check("post_rst_ebreak", ebreak, 1'b0);

        // Random traffic against the model.
        model_reset();
        tick();
        for (int n = 0; n < 1500; n++) begin
            int          sel;
            logic [31:0] d;
            logic [3:0]  ef;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       bus.csr_wr_addr = 12'h7A0;
                1, 2:    bus.csr_wr_addr = 12'h7A1;
                3:       bus.csr_wr_addr = 12'h7A2;
                default: bus.csr_wr_addr = 12'($urandom_range(0, 4095));
            endcase
            d = $urandom;
            if (sel == 0) d = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) d[15:12] = 4'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) d[10:7] = 4'($urandom_range(0, 1));
            d[27] = ($urandom_range(0, 3) == 0);
            bus.csr_wr_data  = d;
            bus.csr_wr_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       bus.csr_rd_addr = 12'h7A0;
                1:       bus.csr_rd_addr = 12'h7A1;
                2:       bus.csr_rd_addr = 12'h7A2;
                default: bus.csr_rd_addr = 12'($urandom_range(0, 4095));
            endcase
            dbg_mode = ($urandom_range(0, 7) == 0);
            match    = 4'($urandom);
            commit   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ef = model_fire(match, commit, dbg_mode);
            check("rnd_fire", fire, ef);
            check("rnd_rd", bus.csr_rd_data, model_read(bus.csr_rd_addr));
            check("rnd_halt", halt, m_halt);
            check("rnd_ebreak", ebreak, m_ebreak);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rnd_pkt%0d", i), pkt[i], model_pkt(i));
            end
            @(posedge clk);
            model_step(bus.csr_wr_valid, bus.csr_wr_addr, bus.csr_wr_data, match, commit, dbg_mode);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
